// File: rtl/stopwatch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl_pkg
// Shared definitions for the stopwatch control path: the 2-bit FSM state
// width and the IDLE/RUN/PAUSE/LAP encodings that are also driven onto the
// state LEDs. Also holds a small helper that tells whether a state lets the
// seconds prescaler run.
// -----------------------------------------------------------------------------
package stopwatch_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;

  // The counter keeps advancing in LAP; only the display is frozen there.
  function automatic logic is_counting(input sw_state_e s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_key_edge.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl_key_edge
// Brings one raw active-low push-button into the clock domain with a two-flop
// synchronizer, keeps one history flop behind it, and emits a registered
// single-cycle press pulse on each falling edge (key going down). A held key
// yields exactly one pulse; releasing a key yields none.
//
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   synchronous, active-low; all flops read as "key released"
//   key_n  in   raw button, active-low, asynchronous to clock
//   press  out  one-cycle pulse, high from edge t+2 to t+3 where t is the
//               first edge that samples key_n low
// -----------------------------------------------------------------------------
module stopwatch_ctrl_key_edge (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  logic sync_p0;
  logic sync_p1;
  logic hist_p2;

  // Stage p0/p1: metastability guard; p2: history for edge detection.
  // Press is registered so the FSM sees a clean, glitch-free pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      hist_p2 <= 1'b1;
      press   <= 1'b0;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
      hist_p2 <= sync_p1;
      press   <= hist_p2 & ~sync_p1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Control FSM for the seconds-counter / BCD display path. Turns the start/stop
// and lap/clear buttons into commands, generates the once-per-TICK_DIV count
// enable for the external counter, and chooses between the live count and a
// frozen lap value for the display chain.
//
// Parameters:
//   N         width of count_q / disp_value
//   TICK_DIV  clock cycles per count tick
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous, active-low
//   key_ss_n    in   raw start/stop button, active-low
//   key_lap_n   in   raw lap/clear button, active-low
//   count_q     in   current external counter value
//   count_en    out  registered one-cycle count tick
//   count_clr   out  registered one-cycle counter clear
//   disp_value  out  lap_reg while frozen, otherwise count_q (combinational)
//   frozen      out  high in LAP
//   state       out  FSM state for the LEDs
// -----------------------------------------------------------------------------
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int N        = 10,
  parameter int TICK_DIV = 50000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               key_ss_n,
  input  logic               key_lap_n,
  input  logic [N-1:0]       count_q,
  output logic               count_en,
  output logic               count_clr,
  output logic [N-1:0]       disp_value,
  output logic               frozen,
  output logic [STATE_W-1:0] state
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  logic ss_press;
  logic lap_press;

  stopwatch_ctrl_key_edge u_key_ss (
    .clock (clock),
    .reset (reset),
    .key_n (key_ss_n),
    .press (ss_press)
  );

  stopwatch_ctrl_key_edge u_key_lap (
    .clock (clock),
    .reset (reset),
    .key_n (key_lap_n),
    .press (lap_press)
  );

  sw_state_e        state_q;
  sw_state_e        state_d;
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic [N-1:0]     lap_reg;
  logic             clr_d;
  logic             tick_d;
  logic             capture;
  logic             pre_zero;
  logic             ss_go;
  logic             lap_go;
  logic             counting;

  // Start/stop has priority: a lap press landing in the same cycle is dropped.
  assign ss_go    = ss_press;
  assign lap_go   = lap_press & ~ss_press;
  assign counting = is_counting(state_q);

  always_comb begin
    state_d  = state_q;
    clr_d    = 1'b0;
    capture  = 1'b0;
    pre_zero = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_go) begin
          state_d = RUN;
        end else if (lap_go) begin
          clr_d = 1'b1;
        end
      end
      RUN: begin
        if (ss_go) begin
          state_d = PAUSE;
        end else if (lap_go) begin
          state_d = LAP;
          capture = 1'b1;
        end
      end
      LAP: begin
        if (ss_go) begin
          state_d = PAUSE;
        end else if (lap_go) begin
          state_d = RUN;
        end
      end
      PAUSE: begin
        if (ss_go) begin
          state_d = RUN;
        end else if (lap_go) begin
          state_d  = IDLE;
          clr_d    = 1'b1;
          pre_zero = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Prescaler runs off the current state, so the edge that leaves RUN/LAP
  // still advances it; PAUSE then holds the partial second. Clears come only
  // from non-counting states, so count_en and count_clr can never coincide.
  always_comb begin
    tick_d = 1'b0;
    pre_d  = pre_q;
    if (pre_zero) begin
      pre_d = '0;
    end else if (counting) begin
      if (pre_q == PRE_LAST) begin
        pre_d  = '0;
        tick_d = 1'b1;
      end else begin
        pre_d = pre_q + PRE_ONE;
      end
    end
  end

  // Control/state registers; reset aborts any pending tick or clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      lap_reg   <= '0;
      count_en  <= 1'b0;
      count_clr <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      count_en  <= tick_d;
      count_clr <= clr_d;
      if (capture) begin
        lap_reg <= count_q;
      end
    end
  end

  assign frozen     = (state_q == LAP);
  assign disp_value = frozen ? lap_reg : count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed bench for stopwatch_ctrl with TICK_DIV=4. Expected tick and clear
// cycles are pushed to queues as stimulus is applied; a monitor pops and
// compares them whenever count_en / count_clr is observed high.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  localparam int N        = 10;
  localparam int TICK_DIV = 4;
  localparam int PRESS_LAT = 7;  // cycles from do_press call to state-change edge

  logic         clock = 1'b0;
  logic         reset;
  logic         key_ss_n;
  logic         key_lap_n;
  logic [N-1:0] count_q;
  logic         count_en;
  logic         count_clr;
  logic [N-1:0] disp_value;
  logic         frozen;
  logic [1:0]   state;

  stopwatch_ctrl #(
    .N        (N),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key_ss_n   (key_ss_n),
    .key_lap_n  (key_lap_n),
    .count_q    (count_q),
    .count_en   (count_en),
    .count_clr  (count_clr),
    .disp_value (disp_value),
    .frozen     (frozen),
    .state      (state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_tick_q[$];
  int exp_clr_q[$];
  int nt = 0;          // next expected tick cycle while counting
  bit counting_m = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge.
  always @(posedge clock) begin
    int e;
    #1;
    if (count_en === 1'b1 || count_clr === 1'b1)
      chk("en_clr_overlap", {31'd0, count_en & count_clr}, 0);
    if (count_en === 1'b1) begin
      chk("tick_expected", (exp_tick_q.size() > 0) ? 1 : 0, 1);
      if (exp_tick_q.size() > 0) begin
        e = exp_tick_q.pop_front();
        chk("tick_cycle", cyc, e);
      end
    end
    if (count_clr === 1'b1) begin
      chk("clr_expected", (exp_clr_q.size() > 0) ? 1 : 0, 1);
      if (exp_clr_q.size() > 0) begin
        e = exp_clr_q.pop_front();
        chk("clr_cycle", cyc, e);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic push_ticks_upto(input int last);
    while (counting_m && nt <= last) begin
      exp_tick_q.push_back(nt);
      nt += TICK_DIV;
    end
  endtask

  task automatic wait_cycles(input int n);
    push_ticks_upto(cyc + n);
    step(n);
  endtask

  // Keys idle high for 3 cycles, then held low 4 cycles; returns at the
  // state-change edge e with the keys released again.
  task automatic do_press(input bit ss, input bit lap, input bit clr, output int e);
    e = cyc + PRESS_LAT;
    push_ticks_upto(e);
    if (clr) exp_clr_q.push_back(e);
    step(3);
    key_ss_n  = ~ss;
    key_lap_n = ~lap;
    step(4);
    key_ss_n  = 1'b1;
    key_lap_n = 1'b1;
  endtask

  // Pause so that the next tick is rem_target cycles away on resume.
  task automatic pause_rem(input int rem_target, input bit ss, input bit lap, output int rem);
    int w;
    int e;
    w = ((nt - cyc - PRESS_LAT - rem_target) % TICK_DIV + TICK_DIV) % TICK_DIV;
    wait_cycles(w);
    do_press(ss, lap, 1'b0, e);
    rem = nt - e;
    counting_m = 1'b0;
  endtask

  initial begin
    int e;
    int rem;

    // Reset with both keys held low.
    reset     = 1'b0;
    key_ss_n  = 1'b0;
    key_lap_n = 1'b0;
    count_q   = 10'd123;
    step(3);
    chk("rst_state", state, 0);
    chk("rst_count_en", count_en, 0);
    chk("rst_count_clr", count_clr, 0);
    chk("rst_frozen", frozen, 0);
    chk("rst_disp", disp_value, 123);
    count_q = 10'd456;
    #1;
    chk("rst_disp_follow", disp_value, 456);
    key_ss_n  = 1'b1;
    key_lap_n = 1'b1;
    step(3);
    reset = 1'b1;
    step(8);
    chk("idle_after_rst", state, 0);
    count_q = 10'd0;

    // IDLE -> RUN, ticks every TICK_DIV starting TICK_DIV after entry.
    do_press(1'b1, 1'b0, 1'b0, e);
    chk("run_state", state, 1);
    nt = e + TICK_DIV;
    counting_m = 1'b1;
    wait_cycles(20);
    chk("run_state_hold", state, 1);
    chk("run_5_ticks_drained", exp_tick_q.size(), 0);

    // Lap freeze while counting continues.
    count_q = 10'd37;
    do_press(1'b0, 1'b1, 1'b0, e);
    chk("lap_state", state, 3);
    chk("lap_frozen", frozen, 1);
    chk("lap_disp", disp_value, 37);
    count_q = 10'd40;
    wait_cycles(8);
    chk("lap_disp_hold", disp_value, 37);
    chk("lap_ticks_drained", exp_tick_q.size(), 0);
    do_press(1'b0, 1'b1, 1'b0, e);
    chk("lap_to_run_state", state, 1);
    chk("lap_to_run_frozen", frozen, 0);
    chk("lap_to_run_disp", disp_value, 40);

    // Pause with 2 cycles of the second left; resume keeps the remainder.
    pause_rem(2, 1'b1, 1'b0, rem);
    chk("pause_state", state, 2);
    wait_cycles(10);
    do_press(1'b1, 1'b0, 1'b0, e);
    chk("resume_state", state, 1);
    nt = e + rem;
    counting_m = 1'b1;
    wait_cycles(rem);
    chk("resume_tick_drained", exp_tick_q.size(), 0);

    // Pause, then lap -> IDLE with clear; IDLE lap gives another clear.
    pause_rem(3, 1'b1, 1'b0, rem);
    chk("pause2_state", state, 2);
    wait_cycles(5);
    do_press(1'b0, 1'b1, 1'b1, e);
    chk("clr_idle_state", state, 0);
    wait_cycles(2);
    chk("clr1_drained", exp_clr_q.size(), 0);
    do_press(1'b0, 1'b1, 1'b1, e);
    chk("idle_lap_state", state, 0);
    wait_cycles(2);
    chk("clr2_drained", exp_clr_q.size(), 0);
    do_press(1'b1, 1'b0, 1'b0, e);
    chk("rerun_state", state, 1);
    nt = e + TICK_DIV;
    counting_m = 1'b1;
    wait_cycles(TICK_DIV);
    chk("pre_cleared_tick_drained", exp_tick_q.size(), 0);

    // Simultaneous presses in RUN: start/stop wins.
    count_q = 10'd55;
    do_press(1'b0, 1'b1, 1'b0, e);
    chk("lap55_disp", disp_value, 55);
    do_press(1'b0, 1'b1, 1'b0, e);
    chk("lap55_back_run", state, 1);
    count_q = 10'd77;
    pause_rem(1, 1'b1, 1'b1, rem);
    chk("both_state", state, 2);
    chk("both_frozen", frozen, 0);
    chk("both_disp", disp_value, 77);
    do_press(1'b1, 1'b0, 1'b0, e);
    chk("both_resume_state", state, 1);
    nt = e + rem;
    counting_m = 1'b1;
    count_q = 10'd88;
    do_press(1'b0, 1'b1, 1'b0, e);
    chk("lap88_state", state, 3);
    chk("lap88_disp", disp_value, 88);

    // Reset in LAP aborts on that same edge; no pending tick survives.
    counting_m = 1'b0;
    reset = 1'b0;
    step(1);
    chk("rst_lap_state", state, 0);
    chk("rst_lap_frozen", frozen, 0);
    chk("rst_lap_count_en", count_en, 0);
    chk("rst_lap_disp", disp_value, 88);
    step(2);
    reset = 1'b1;
    wait_cycles(6);
    chk("final_state", state, 0);
    chk("final_tick_q", exp_tick_q.size(), 0);
    chk("final_clr_q", exp_clr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
